// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
// Operand-mux select encodings and the destination-scoreboard entry layout.
package fwd_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_SEL_RF    = 2'b00;
    localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
    localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;
    localparam logic [1:0] FWD_SEL_WBBUF = 2'b11;

    // Scoreboard rd field is wide enough for any supported REG_ADDR_W; narrower
    // addresses are zero-extended into it.
    localparam int unsigned SB_RD_W = 8;

    typedef logic [SB_RD_W-1:0] sb_rd_t;

    typedef struct packed {
        logic   valid;
        sb_rd_t rd;
        logic   reg_write;
        logic   mem_read;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // x0 is hardwired to zero, so it never produces a forwarding hit.
    function automatic logic sb_hit(input sb_entry_t e, input sb_rd_t rs, input logic used);
        return used && e.valid && e.reg_write && (e.rd != '0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage decode info in, operand-mux selects and pipeline stall/bubble out.
// master = pipeline side, slave = fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  muldiv_busy;
    logic [1:0]            fwd_a_select;
    logic [1:0]            fwd_b_select;
    logic                  stall;
    logic                  bubble;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_mem_read, flush, muldiv_busy,
        input  fwd_a_select, fwd_b_select, stall, bubble
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_mem_read, flush, muldiv_busy,
        output fwd_a_select, fwd_b_select, stall, bubble
    );
endinterface

// File: rtl/fwd_src_match.sv
// Priority compare of one source register against the EX/MEM/WB scoreboard slots.
// The WB-slot compare exists only when FWD_WB_BUFFER_EN is defined.
module fwd_src_match
    import fwd_hazard_ctrl_pkg::*;
(
    input  sb_rd_t     rs,
    input  logic       used,
    input  sb_entry_t  ex,
    input  sb_entry_t  mem,
    input  sb_entry_t  wb,
    output logic [1:0] sel,
    output logic       load_hit
);
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = sb_hit(ex, rs, used);
    assign mem_hit = sb_hit(mem, rs, used);

`ifdef FWD_WB_BUFFER_EN
    assign wb_hit = sb_hit(wb, rs, used);
`else
    // Without the buffer the register file writes early enough to be read directly.
    logic unused_wb;
    assign unused_wb = ^wb;
    assign wb_hit    = 1'b0;
`endif

    // A load in EX has no data yet; the controller stalls, so it falls through here.
    always_comb begin
        sel = FWD_SEL_RF;
        if (ex_hit && !ex.mem_read) begin
            sel = FWD_SEL_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_SEL_MEMWB;
        end else if (wb_hit) begin
            sel = FWD_SEL_WBBUF;
        end
    end

    assign load_hit = ex_hit && ex.mem_read;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: registered EX operand-mux selects, load-use and
// mul/div stall/bubble generation. FWD_WB_BUFFER_EN enables select 11 (WB buffer).
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    fwd_hazard_ctrl_if.slave bus
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;

    sb_entry_t  id_entry;
    sb_entry_t  ex_q, ex_d;
    sb_entry_t  mem_q, mem_d;
    sb_entry_t  wb_q, wb_d;
    logic [1:0] sel_a_q, sel_a_d, sel_a_nxt;
    logic [1:0] sel_b_q, sel_b_d, sel_b_nxt;
    logic       hit_a, hit_b;
    logic       load_use;

    assign id_rs1 = bus.id_rs1;
    assign id_rs2 = bus.id_rs2;
    assign id_rd  = bus.id_rd;

    always_comb begin
        id_entry = SB_BUBBLE;
        if (bus.id_valid) begin
            id_entry.valid     = 1'b1;
            id_entry.rd        = sb_rd_t'(id_rd);
            id_entry.reg_write = bus.id_reg_write;
            id_entry.mem_read  = bus.id_mem_read;
        end
    end

    fwd_src_match u_match_a (
        .rs       (sb_rd_t'(id_rs1)),
        .used     (bus.id_rs1_used),
        .ex       (ex_q),
        .mem      (mem_q),
        .wb       (wb_q),
        .sel      (sel_a_nxt),
        .load_hit (hit_a)
    );

    fwd_src_match u_match_b (
        .rs       (sb_rd_t'(id_rs2)),
        .used     (bus.id_rs2_used),
        .ex       (ex_q),
        .mem      (mem_q),
        .wb       (wb_q),
        .sel      (sel_b_nxt),
        .load_hit (hit_b)
    );

    assign load_use = bus.id_valid && (hit_a || hit_b);

    // Advance priority: mul/div freeze, then flush, then load-use, then normal.
    always_comb begin
        ex_d    = id_entry;
        mem_d   = ex_q;
        wb_d    = mem_q;
        sel_a_d = sel_a_nxt;
        sel_b_d = sel_b_nxt;
        if (bus.muldiv_busy) begin
            ex_d    = ex_q;
            mem_d   = SB_BUBBLE;
            sel_a_d = sel_a_q;
            sel_b_d = sel_b_q;
        end else if (bus.flush || load_use) begin
            ex_d    = SB_BUBBLE;
            sel_a_d = FWD_SEL_RF;
            sel_b_d = FWD_SEL_RF;
        end
    end

    always_comb begin
        bus.stall  = 1'b0;
        bus.bubble = 1'b0;
        if (!reset) begin
            if (bus.muldiv_busy) begin
                bus.stall = 1'b1;
            end else if (bus.flush) begin
                bus.bubble = 1'b1;
            end else if (load_use) begin
                bus.stall  = 1'b1;
                bus.bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= SB_BUBBLE;
            mem_q   <= SB_BUBBLE;
            wb_q    <= SB_BUBBLE;
            sel_a_q <= FWD_SEL_RF;
            sel_b_q <= FWD_SEL_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign bus.fwd_a_select = sel_a_q;
    assign bus.fwd_b_select = sel_b_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the RV32IM 5-stage pipeline. It drives the SELECT inputs of the two EX-stage 32-bit 4:1 operand muxes, which feed ALU operands A and B. It keeps its own 3-entry destination scoreboard (EX, MEM, WB slots) that advances in lockstep with the pipeline registers. It also generates load-use and mul/div stall and bubble controls for the IF/ID and ID/EX registers.

## Interface
- Parameters:
- `REG_ADDR_W`, default 5: register address width.
- Ports:
- `CLK` input 1: pipeline clock, rising edge.
- `RESET` input 1: asynchronous, active-high.
- `ID_VALID` input 1: a real instruction is in ID.
- `ID_RS1`, `ID_RS2` input REG_ADDR_W: source registers of the ID instruction.
- `ID_RS1_USED`, `ID_RS2_USED` input 1: the ID instruction reads that source.
- `ID_RD` input REG_ADDR_W: destination register of the ID instruction.
- `ID_REG_WRITE` input 1: the ID instruction writes `ID_RD`.
- `ID_MEM_READ` input 1: the ID instruction is a load.
- `FLUSH` input 1: taken branch or jump resolved in EX.
- `MULDIV_BUSY` input 1: multi-cycle mul/div occupying EX.
- `FWD_A_SELECT`, `FWD_B_SELECT` output 2: registered operand-mux selects, valid while the instruction is in EX.
- `STALL` output 1: hold PC and IF/ID.
- `BUBBLE` output 1: load NOP into ID/EX.

## Operation
- Mux select encoding:
  - 00 = register-file data.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB writeback data.
  - 11 = WB buffer (value written the previous cycle).
- Scoreboard slot contents: {valid, rd, reg_write, mem_read}. A slot matches a source when it is valid, reg_write=1, rd≠0, rd==rs, and the source is used.
- Next selects are computed in ID, per operand:
  - EX-slot match and slot is not a load → 01.
  - Otherwise MEM-slot match → 10.
  - Otherwise WB-slot match → 11. This case depends on the macro (see Configuration).
  - Otherwise → 00.
  - The nearest (youngest) producer always wins.
- Load-use: the EX slot is a load matching either used source while ID_VALID=1. Then STALL=1 and BUBBLE=1 for exactly one cycle. On the following cycle the load sits in the MEM slot and the select resolves to 10.
- Advance priority per cycle, highest first:
  - **MULDIV_BUSY.** ID and EX slots frozen; select registers held; MEM slot ← bubble; WB ← MEM; STALL=1, BUBBLE=0. FLUSH is ignored in this cycle.
  - **FLUSH.** EX slot ← bubble; selects ← 00; MEM ← EX; WB ← MEM; STALL=0, BUBBLE=1. This overrides a coincident load-use stall.
  - **Load-use.** EX slot ← bubble; selects ← 00; MEM ← EX; WB ← MEM.
  - **Normal.** EX ← ID entry (a bubble if ID_VALID=0); selects ← computed values; MEM ← EX; WB ← MEM.
- Register x0 is never forwarded.

## Timing
- Reset (asynchronous):
  - All slots invalid.
  - `FWD_A_SELECT` and `FWD_B_SELECT` = 00.
  - `STALL` and `BUBBLE` forced to 0 while RESET is high.
- `STALL` and `BUBBLE` are combinational from the ID inputs, the scoreboard and `MULDIV_BUSY`. They are valid before the rising edge in the same cycle.
- Selects have 1-cycle latency: computed in ID, registered at the edge where the instruction enters EX.
- A load-use stall lasts exactly 1 cycle. Back-to-back load-use pairs each cost 1 cycle.
- A mul/div stall lasts as long as `MULDIV_BUSY` is high. The release cycle behaves as a normal advance.
- Reset asserted mid-stall clears everything immediately. The first cycle after release is a normal advance with an empty scoreboard.

## Configuration
- `FWD_WB_BUFFER_EN` defined:
  - A WB-slot match yields select 11.
  - The datapath latches writeback data for one extra cycle into mux input 3.
- `FWD_WB_BUFFER_EN` undefined:
  - The WB slot is not compared; a WB-slot match yields 00.
  - The register file must write in the first half-cycle, so the read returns the new value.
  - Select 11 is never produced.

## Structure
- Shared package holds:
  - `FWD_SEL_RF`=2'b00, `FWD_SEL_EXMEM`=2'b01, `FWD_SEL_MEMWB`=2'b10, `FWD_SEL_WBBUF`=2'b11.
  - The scoreboard-entry struct typedef {valid, rd, reg_write, mem_read}.
- One sub-module, `fwd_src_match`, instantiated twice (once per operand). It is combinational: priority compare of one source against the three slots, returning the select and a load-hit flag.

## Test plan
- **EX-to-EX forwarding.**
  - Stimulus: `add x5,x1,x2` followed by `sub x6,x5,x3`.
  - Required: when `sub` is in EX, FWD_A_SELECT=01, FWD_B_SELECT=00; STALL stays 0.
- **Load-use with operand B.**
  - Stimulus: `lw x7,0(x1)` followed by `add x8,x2,x7`.
  - Required: STALL=BUBBLE=1 for one cycle; the next cycle the `add` enters EX with FWD_B_SELECT=10.
- **Distance-3 dependency.**
  - Stimulus: `add x9,…` followed by two independent instructions, then `or x10,x9,x9`.
  - Required: both selects are 11 with the macro defined, 00 without it.
- **x0 and priority.**
  - Stimulus: writes to x0 in the EX and MEM slots with a reader of x0 in ID. Then writes to x4 in both the EX and MEM slots.
  - Required: the x0 reader gets selects 00. The x4 reader gets 01 (the EX slot wins).
- **Flush during load-use, then mul/div.**
  - Stimulus: FLUSH=1 coincident with a load-use hazard. Then MULDIV_BUSY=1 for 4 cycles.
  - Required (flush): STALL=0, BUBBLE=1, selects 00.
  - Required (mul/div): STALL=1 for 4 cycles, selects held, MEM slot receives a bubble each of those cycles.
- **Reset mid-stall.**
  - Stimulus: assert RESET asynchronously while MULDIV_BUSY=1.
  - Required: STALL drops to 0 without waiting for a clock edge; selects become 00.
